// File: rtl/rvdff_pipe.sv
// Elastic valid/ready delay line of DEPTH registered stages; invalid stages refill even under a downstream stall.
// Optional RVPIPE_FLUSH_EN adds a flush input that empties the pipe without touching data.
module rvdff_pipe #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 3,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_l,
`ifdef RVPIPE_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] src_vld;
    logic [WIDTH-1:0] src_dat [DEPTH];
    logic             flush_act;

`ifdef RVPIPE_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    // Ready ripples from the output side: a stage can load if it is empty or its successor can load.
    always_comb begin
        logic r;
        r   = out_ready;
        rdy = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            r      = !vld[i] | r;
            rdy[i] = r;
        end
    end

    always_comb begin
        src_vld[0] = in_valid;
        src_dat[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_vld[i] = vld[i-1];
            src_dat[i] = dat[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
        end else if (flush_act) begin
            vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    vld[i] <= src_vld[i];
                    if (src_vld[i]) dat[i] <= src_dat[i];
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(vld[i]);
    end

    // Flush masks both handshakes so nothing transfers during the clearing cycle.
    assign in_ready  = rdy[0] & !flush_act;
    assign out_valid = vld[DEPTH-1] & !flush_act;
    assign out_data  = dat[DEPTH-1];

endmodule

// File: tb/tb_rvdff_pipe.sv
// Directed bench for rvdff_pipe (WIDTH=16, DEPTH=3); the flush scenario runs only when RVPIPE_FLUSH_EN is defined.
module tb_rvdff_pipe;

    localparam int WIDTH = 16;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst_l;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       occupancy;
`ifdef RVPIPE_FLUSH_EN
    logic             flush;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rvdff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_l     (rst_l),
`ifdef RVPIPE_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then leave time for outputs to settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int acc;
        rst_l     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef RVPIPE_FLUSH_EN
        flush     = 1'b0;
`endif
        tick();
        tick();
        rst_l = 1'b1;
        settle();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data), 0);
        chk("rst_occ",       32'(occupancy), 0);
        chk("rst_in_ready",  32'(in_ready), 1);

        // T1: single beat, latency DEPTH
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'hA5A5;
        settle();
        chk("t1_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        settle();
        chk("t1_c1_valid", 32'(out_valid), 0);
        chk("t1_c1_occ",   32'(occupancy), 1);
        tick();
        chk("t1_c2_valid", 32'(out_valid), 0);
        chk("t1_c2_occ",   32'(occupancy), 1);
        tick();
        chk("t1_c3_valid", 32'(out_valid), 1);
        chk("t1_c3_data",  32'(out_data), 32'hA5A5);
        chk("t1_c3_occ",   32'(occupancy), 1);
        tick();
        chk("t1_c4_valid", 32'(out_valid), 0);
        chk("t1_c4_occ",   32'(occupancy), 0);

        // T2: back-to-back stream 1..16
        for (int c = 0; c < 16 + DEPTH; c++) begin
            in_valid = (c < 16);
            in_data  = 16'(c + 1);
            settle();
            if (c < 16) chk("t2_in_ready", 32'(in_ready), 1);
            if (c < DEPTH) begin
                chk("t2_lead_valid", 32'(out_valid), 0);
            end else begin
                chk("t2_valid", 32'(out_valid), 1);
                chk("t2_data",  32'(out_data), 32'(c - DEPTH + 1));
            end
            tick();
        end
        in_valid = 1'b0;
        settle();
        chk("t2_end_occ", 32'(occupancy), 0);

        // T3: fill under stall, then simultaneous accept and emit
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h100 + acc);
            settle();
            if (!in_ready) break;
            acc++;
            tick();
        end
        chk("t3_accepted", 32'(acc), DEPTH);
        chk("t3_full_occ", 32'(occupancy), DEPTH);
        chk("t3_full_rdy", 32'(in_ready), 0);
        chk("t3_full_data", 32'(out_data), 32'h100);
        tick();
        chk("t3_hold_occ",  32'(occupancy), DEPTH);
        chk("t3_hold_data", 32'(out_data), 32'h100);
        out_ready = 1'b1;
        in_data   = 16'h103;
        settle();
        chk("t3_pass_rdy",   32'(in_ready), 1);
        chk("t3_pass_valid", 32'(out_valid), 1);
        chk("t3_pass_data",  32'(out_data), 32'h100);
        tick();
        in_valid = 1'b0;
        settle();
        chk("t3_pass_occ", 32'(occupancy), DEPTH);
        for (int k = 1; k <= 3; k++) begin
            chk("t3_drain_data", 32'(out_data), 32'(32'h100 + k));
            tick();
        end
        chk("t3_drain_occ", 32'(occupancy), 0);

        // T4: bubble collapse under stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hAAAA;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = 16'hBBBB;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t4_occ",   32'(occupancy), 2);
        chk("t4_valid", 32'(out_valid), 1);
        chk("t4_data",  32'(out_data), 32'hAAAA);
        chk("t4_slot",  32'(dut.vld), 32'b110);
        tick();
        chk("t4_stall_occ", 32'(occupancy), 2);
        out_ready = 1'b1;
        settle();
        chk("t4_first", 32'(out_data), 32'hAAAA);
        tick();
        chk("t4_second_valid", 32'(out_valid), 1);
        chk("t4_second", 32'(out_data), 32'hBBBB);
        tick();
        chk("t4_empty", 32'(occupancy), 0);

        // T5: reset with two beats in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hC0C0;
        tick();
        in_data = 16'hD0D0;
        tick();
        in_valid = 1'b0;
        settle();
        chk("t5_pre_occ", 32'(occupancy), 2);
        rst_l    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hEEEE;
        tick();
        rst_l    = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_l = 1'b1;
        settle();
        chk("t5_valid", 32'(out_valid), 0);
        chk("t5_data",  32'(out_data), 0);
        chk("t5_occ",   32'(occupancy), 0);
        chk("t5_rdy",   32'(in_ready), 1);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t5_no_stale", 32'(out_valid), 0);
        end

`ifdef RVPIPE_FLUSH_EN
        // T6: flush a full pipe
        out_ready = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h200 + c);
            tick();
        end
        settle();
        chk("t6_full", 32'(occupancy), DEPTH);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 16'h2FF;
        settle();
        chk("t6_flush_rdy",   32'(in_ready), 0);
        chk("t6_flush_valid", 32'(out_valid), 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        settle();
        chk("t6_after_occ", 32'(occupancy), 0);
        chk("t6_after_rdy", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t6_new_valid", 32'(out_valid), 1);
        chk("t6_new_data",  32'(out_data), 32'h1234);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
